// File: rtl/sdram_arbit_rr.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arbit_rr
//  Description : SDRAM command arbiter and pin multiplexer. Client 0 (refresh)
//                has fixed top priority; clients 1..N_CH-1 are served
//                round-robin. The init sequencer owns the pins until
//                flag_init_end. A per-grant watchdog frees a hung bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbit_rr #(
    parameter int N_CH        = 3,
    parameter int ADDR_W      = 12,
    parameter int BANK_W      = 2,
    parameter int DQ_W        = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                              sclk,
    input  logic                              s_rst_n,
    input  logic                              flag_init_end,
    input  logic [3:0]                        init_cmd,
    input  logic [ADDR_W-1:0]                 init_addr,
    input  logic [N_CH-1:0]                   cl_req,
    output logic [N_CH-1:0]                   cl_en,
    input  logic [N_CH-1:0]                   cl_end,
    input  logic [4*N_CH-1:0]                 cl_cmd,
    input  logic [ADDR_W*N_CH-1:0]            cl_addr,
    input  logic [BANK_W*N_CH-1:0]            cl_bank,
    input  logic [DQ_W*N_CH-1:0]              cl_dq,
    input  logic [N_CH-1:0]                   cl_dq_oe,
    output logic                              sdram_clk,
    output logic                              sdram_cke,
    output logic                              sdram_cs_n,
    output logic                              sdram_ras_n,
    output logic                              sdram_cas_n,
    output logic                              sdram_we_n,
    output logic [BANK_W-1:0]                 sdram_bank,
    output logic [ADDR_W-1:0]                 sdram_addr,
    output logic [DQ_W/8-1:0]                 sdram_dqm,
    output logic [DQ_W-1:0]                   sdram_dq_out,
    output logic                              sdram_dq_oe,
    output logic [((N_CH>1)?$clog2(N_CH):1)-1:0] cur_owner,
    output logic                              timeout_err
);

    localparam int               OW        = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int               WDW       = $clog2(TIMEOUT_CYC);
    localparam logic [3:0]       C_NOP     = 4'b0111;
    localparam logic [WDW-1:0]   C_WD_LAST = WDW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ARBIT = 3'b010,
        S_BUSY  = 3'b100
    } state_t;

    state_t             state_q, state_d;
    logic [N_CH-1:0]    cl_en_q, cl_en_d;
    logic [OW-1:0]      cur_owner_q, cur_owner_d;
    logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WDW-1:0]     wd_cnt_q, wd_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic               w_win_vld;
    logic [OW-1:0]      w_win_idx;
    logic [3:0]         w_own_cmd;
    logic [ADDR_W-1:0]  w_own_addr;
    logic [BANK_W-1:0]  w_own_bank;
    logic [DQ_W-1:0]    w_own_dq;
    logic               w_own_oe;
    logic               w_own_end;
    logic [3:0]         w_cmd;

    // Pick the winner: refresh first, else the first data client after rr_ptr.
    always_comb begin
        int cand;
        cand      = 0;
        w_win_vld = 1'b0;
        w_win_idx = '0;
        if (cl_req[0]) begin
            w_win_vld = 1'b1;
        end else begin
            for (int k = 1; k < N_CH; k++) begin
                cand = ((int'(rr_ptr_q) - 1 + k) % (N_CH - 1)) + 1;
                if (!w_win_vld && cl_req[cand]) begin
                    w_win_vld = 1'b1;
                    w_win_idx = OW'(cand);
                end
            end
        end
    end

    // Select the current owner's pin fields and end strobe.
    always_comb begin
        w_own_cmd  = C_NOP;
        w_own_addr = '0;
        w_own_bank = '0;
        w_own_dq   = '0;
        w_own_oe   = 1'b0;
        w_own_end  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cur_owner_q == OW'(i)) begin
                w_own_cmd  = cl_cmd[4*i +: 4];
                w_own_addr = cl_addr[ADDR_W*i +: ADDR_W];
                w_own_bank = cl_bank[BANK_W*i +: BANK_W];
                w_own_dq   = cl_dq[DQ_W*i +: DQ_W];
                w_own_oe   = cl_dq_oe[i];
                w_own_end  = cl_end[i];
            end
        end
    end

    // State register and arbitration bookkeeping.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q       <= S_IDLE;
            cl_en_q       <= '0;
            cur_owner_q   <= '0;
            rr_ptr_q      <= OW'(N_CH - 1);
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cl_en_q       <= cl_en_d;
            cur_owner_q   <= cur_owner_d;
            rr_ptr_q      <= rr_ptr_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state: grant on arbitration, release on owner end or watchdog expiry.
    always_comb begin
        state_d       = state_q;
        cl_en_d       = '0;
        cur_owner_d   = cur_owner_q;
        rr_ptr_d      = rr_ptr_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (flag_init_end) state_d = S_ARBIT;
            end
            S_ARBIT: begin
                if (w_win_vld) begin
                    state_d     = S_BUSY;
                    cl_en_d     = N_CH'(1) << w_win_idx;
                    cur_owner_d = w_win_idx;
                    wd_cnt_d    = '0;
                    // Refresh grants must not disturb the data clients' rotation.
                    if (w_win_idx != '0) rr_ptr_d = w_win_idx;
                end
            end
            S_BUSY: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                if (w_own_end) begin
                    state_d = S_ARBIT;
                end else if (wd_cnt_q == C_WD_LAST) begin
                    state_d       = S_ARBIT;
                    timeout_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin multiplexer, purely a function of state and owner.
    always_comb begin
        w_cmd        = C_NOP;
        sdram_addr   = '0;
        sdram_bank   = '0;
        sdram_dq_out = '0;
        sdram_dq_oe  = 1'b0;
        case (state_q)
            S_IDLE: begin
                w_cmd      = init_cmd;
                sdram_addr = init_addr;
            end
            S_BUSY: begin
                w_cmd        = w_own_cmd;
                sdram_addr   = w_own_addr;
                sdram_bank   = w_own_bank;
                sdram_dq_out = w_own_dq;
                sdram_dq_oe  = w_own_oe;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
    assign sdram_clk   = ~sclk;
    assign sdram_cke   = 1'b1;
    assign sdram_dqm   = '0;
    assign cl_en       = cl_en_q;
    assign cur_owner   = cur_owner_q;
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_arbit_rr
//  Description : Directed self-checking bench for sdram_arbit_rr.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbit_rr;

    localparam int N_CH = 3;
    localparam int AW   = 12;
    localparam int BW   = 2;
    localparam int DW   = 16;
    localparam int TO   = 16;

    logic              sclk = 1'b0;
    logic              s_rst_n;
    logic              flag_init_end;
    logic [3:0]        init_cmd;
    logic [AW-1:0]     init_addr;
    logic [N_CH-1:0]   cl_req, cl_en, cl_end, cl_dq_oe;
    logic [4*N_CH-1:0] cl_cmd;
    logic [AW*N_CH-1:0] cl_addr;
    logic [BW*N_CH-1:0] cl_bank;
    logic [DW*N_CH-1:0] cl_dq;
    logic              sdram_clk, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BW-1:0]     sdram_bank;
    logic [AW-1:0]     sdram_addr;
    logic [DW/8-1:0]   sdram_dqm;
    logic [DW-1:0]     sdram_dq_out;
    logic              sdram_dq_oe;
    logic [1:0]        cur_owner;
    logic              timeout_err;
    logic [3:0]        pins;

    int n_checks = 0;
    int n_fail   = 0;

    assign pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

    always #5 sclk = ~sclk;

    sdram_arbit_rr #(.N_CH(N_CH), .ADDR_W(AW), .BANK_W(BW), .DQ_W(DW), .TIMEOUT_CYC(TO)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .cl_req(cl_req), .cl_en(cl_en), .cl_end(cl_end),
        .cl_cmd(cl_cmd), .cl_addr(cl_addr), .cl_bank(cl_bank), .cl_dq(cl_dq), .cl_dq_oe(cl_dq_oe),
        .sdram_clk(sdram_clk), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_bank(sdram_bank), .sdram_addr(sdram_addr), .sdram_dqm(sdram_dqm),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
        .cur_owner(cur_owner), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // Reset, then release and leave the DUT in ARBIT.
    task automatic reset_and_init();
        s_rst_n = 1'b0;
        flag_init_end = 1'b0;
        cl_req = '0;
        cl_end = '0;
        tick();
        s_rst_n = 1'b1;
        tick();
        flag_init_end = 1'b1;
        tick();
        flag_init_end = 1'b0;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0;
        tick();
        n_checks++; if (cl_en !== 3'b000) begin n_fail++; $display("FAIL reset_cl_en got %b want 000", cl_en); end
        n_checks++; if (cur_owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got %0d want 0", cur_owner); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
        n_checks++; if ({sdram_cke, sdram_dqm, sdram_dq_oe} !== {1'b1, 2'b00, 1'b0}) begin n_fail++;
            $display("FAIL reset_const got cke=%b dqm=%b oe=%b want 1 00 0", sdram_cke, sdram_dqm, sdram_dq_oe); end
        n_checks++; if (sdram_clk !== 1'b0) begin n_fail++; $display("FAIL sdram_clk got %b want 0 (sclk high)", sdram_clk); end
        s_rst_n = 1'b1;
    endtask

    task automatic test_init();
        tick(); tick();
        n_checks++; if (pins !== 4'b0010 || sdram_addr !== 12'h400 || sdram_bank !== 2'd0) begin n_fail++;
            $display("FAIL init_pins got cmd=%b addr=%h bank=%0d want 0010 400 0", pins, sdram_addr, sdram_bank); end
        flag_init_end = 1'b1;
        tick();
        flag_init_end = 1'b0;
        n_checks++; if (pins !== 4'b0111 || sdram_addr !== 12'h000) begin n_fail++;
            $display("FAIL init_to_arbit got cmd=%b addr=%h want 0111 000", pins, sdram_addr); end
        tick();
        n_checks++; if (pins !== 4'b0111 || cl_en !== 3'b000) begin n_fail++;
            $display("FAIL arbit_idle got cmd=%b en=%b want 0111 000", pins, cl_en); end
    endtask

    task automatic test_priority();
        cl_req = 3'b111;
        tick();
        n_checks++; if (cl_en !== 3'b001 || cur_owner !== 2'd0) begin n_fail++;
            $display("FAIL prio_refresh got en=%b owner=%0d want 001 0", cl_en, cur_owner); end
        n_checks++; if (pins !== 4'b0001 || sdram_addr !== 12'h0A0 || sdram_bank !== 2'd1) begin n_fail++;
            $display("FAIL prio_pins0 got cmd=%b addr=%h bank=%0d want 0001 0a0 1", pins, sdram_addr, sdram_bank); end
        cl_req = 3'b110;
        tick();
        n_checks++; if (cl_en !== 3'b000) begin n_fail++; $display("FAIL en_pulse got %b want 000", cl_en); end
        cl_end = 3'b001;
        tick();
        cl_end = 3'b000;
        n_checks++; if (pins !== 4'b0111) begin n_fail++; $display("FAIL prio_release got cmd=%b want 0111", pins); end
        tick();
        n_checks++; if (cl_en !== 3'b010 || cur_owner !== 2'd1) begin n_fail++;
            $display("FAIL prio_write got en=%b owner=%0d want 010 1", cl_en, cur_owner); end
        cl_req = 3'b100;
        cl_end = 3'b100;
        tick();
        cl_end = 3'b000;
        n_checks++; if (pins !== 4'b0100) begin n_fail++;
            $display("FAIL nonowner_end got cmd=%b want 0100 (still busy)", pins); end
        cl_end = 3'b010;
        tick();
        cl_end = 3'b000;
        tick();
        n_checks++; if (cl_en !== 3'b100 || cur_owner !== 2'd2) begin n_fail++;
            $display("FAIL prio_read got en=%b owner=%0d want 100 2", cl_en, cur_owner); end
        cl_req = 3'b000;
        cl_end = 3'b100;
        tick();
        cl_end = 3'b000;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_en [4];
        exp_en[0] = 3'b010; exp_en[1] = 3'b100; exp_en[2] = 3'b010; exp_en[3] = 3'b100;
        cl_req = 3'b110;
        for (int g = 0; g < 4; g++) begin
            tick();
            n_checks++; if (cl_en !== exp_en[g]) begin n_fail++;
                $display("FAIL rr_grant%0d got %b want %b", g, cl_en, exp_en[g]); end
            tick(); tick();
            cl_end = exp_en[g];
            tick();
            cl_end = 3'b000;
        end
        cl_req = 3'b000;
        tick();
    endtask

    task automatic test_watchdog();
        cl_req = 3'b010;
        tick();
        cl_req = 3'b000;
        n_checks++; if (cl_en !== 3'b010) begin n_fail++; $display("FAIL wd_grant got %b want 010", cl_en); end
        for (int c = 0; c < TO - 1; c++) tick();
        n_checks++; if (pins !== 4'b0100 || timeout_err !== 1'b0) begin n_fail++;
            $display("FAIL wd_cycle16 got cmd=%b err=%b want 0100 0", pins, timeout_err); end
        tick();
        n_checks++; if (pins !== 4'b0111 || timeout_err !== 1'b1) begin n_fail++;
            $display("FAIL wd_expire got cmd=%b err=%b want 0111 1", pins, timeout_err); end
        tick();
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL wd_sticky got %b want 1", timeout_err); end
        reset_and_init();
        cl_req = 3'b010;
        tick();
        cl_req = 3'b000;
        for (int c = 0; c < TO - 1; c++) tick();
        cl_end = 3'b010;
        tick();
        cl_end = 3'b000;
        n_checks++; if (pins !== 4'b0111 || timeout_err !== 1'b0) begin n_fail++;
            $display("FAIL wd_end_wins got cmd=%b err=%b want 0111 0", pins, timeout_err); end
    endtask

    task automatic test_dq_mux();
        cl_dq_oe = 3'b011;
        cl_req = 3'b010;
        tick();
        cl_req = 3'b000;
        n_checks++; if (sdram_dq_out !== 16'hA5A5 || sdram_dq_oe !== 1'b1 || sdram_addr !== 12'h1A1 || sdram_bank !== 2'd2) begin n_fail++;
            $display("FAIL dq_owner1 got dq=%h oe=%b addr=%h bank=%0d want a5a5 1 1a1 2", sdram_dq_out, sdram_dq_oe, sdram_addr, sdram_bank); end
        cl_end = 3'b010;
        tick();
        cl_end = 3'b000;
        n_checks++; if (sdram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL dq_arbit_oe got %b want 0", sdram_dq_oe); end
        cl_req = 3'b100;
        tick();
        cl_req = 3'b000;
        n_checks++; if (sdram_dq_out !== 16'h5A5A || sdram_dq_oe !== 1'b0 || pins !== 4'b0101) begin n_fail++;
            $display("FAIL dq_owner2 got dq=%h oe=%b cmd=%b want 5a5a 0 0101", sdram_dq_out, sdram_dq_oe, pins); end
    endtask

    task automatic test_reset_mid_busy();
        cl_end = 3'b100;
        tick();
        cl_end = 3'b000;
        cl_req = 3'b100;
        tick();
        cl_req = 3'b000;
        n_checks++; if (cl_en !== 3'b100 || cur_owner !== 2'd2) begin n_fail++;
            $display("FAIL mid_busy_grant got en=%b owner=%0d want 100 2", cl_en, cur_owner); end
        #1;
        s_rst_n = 1'b0;
        #1;
        n_checks++; if (cl_en !== 3'b000 || cur_owner !== 2'd0 || timeout_err !== 1'b0 || pins !== 4'b0010) begin n_fail++;
            $display("FAIL async_reset got en=%b owner=%0d err=%b cmd=%b want 000 0 0 0010", cl_en, cur_owner, timeout_err, pins); end
        tick();
        s_rst_n = 1'b1;
        tick();
        n_checks++; if (pins !== 4'b0010) begin n_fail++; $display("FAIL reinit_idle got cmd=%b want 0010", pins); end
    endtask

    initial begin
        s_rst_n       = 1'b0;
        flag_init_end = 1'b0;
        init_cmd      = 4'b0010;
        init_addr     = 12'h400;
        cl_req        = '0;
        cl_end        = '0;
        cl_dq_oe      = '0;
        cl_cmd        = {4'b0101, 4'b0100, 4'b0001};
        cl_addr       = {12'h2A2, 12'h1A1, 12'h0A0};
        cl_bank       = {2'd3, 2'd2, 2'd1};
        cl_dq         = {16'h5A5A, 16'hA5A5, 16'h1111};
        test_reset();
        test_init();
        test_priority();
        test_round_robin();
        test_watchdog();
        test_dq_mux();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
